// File: rtl/freq_meas_sequencer.sv
// Command-driven sequencer for a shared frequency-measurement unit: selects and
// synchronises one input wave, runs the unit, and returns count plus status.
module freq_meas_sequencer #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned NUM_CHANNELS = 8,
    parameter int unsigned CH_WIDTH     = 8,
    parameter int unsigned TO_WIDTH     = 24
) (
    input  logic                    Clock,
    input  logic                    nReset,
    input  logic [NUM_CHANNELS-1:0] in_waves,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CH_WIDTH-1:0]     cmd_channel,
    input  logic [DATA_WIDTH-1:0]   cmd_samples,
    input  logic [TO_WIDTH-1:0]     cmd_timeout,
    input  logic                    cmd_abort,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_value,
    output logic [CH_WIDTH-1:0]     res_channel,
    output logic [1:0]              res_status,
    output logic                    meas_nReset,
    output logic                    meas_enable,
    output logic [DATA_WIDTH-1:0]   meas_samples,
    output logic                    meas_wave,
    input  logic                    meas_done,
    input  logic [DATA_WIDTH-1:0]   meas_value
);

    localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
    localparam logic [1:0] STATUS_BAD_CMD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SETTLE,
        ST_MEASURE,
        ST_REPORT
    } state_t;

    state_t                state;
    logic                  settle_cnt;
    logic [TO_WIDTH-1:0]   to_limit;
    logic [TO_WIDTH-1:0]   to_cnt;
    logic                  to_hit;
    logic                  sync1;
    logic                  wave_sel_c;
    logic                  bad_cmd_c;

    // res_channel doubles as the mux index; it only moves on command acceptance
    always_comb begin
        wave_sel_c = 1'b0;
        if (32'(res_channel) < NUM_CHANNELS)
            wave_sel_c = in_waves[res_channel[IDX_W-1:0]];
    end

    assign bad_cmd_c = (cmd_samples == '0) || (32'(cmd_channel) >= NUM_CHANNELS);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state        <= ST_IDLE;
            settle_cnt   <= 1'b0;
            to_limit     <= '0;
            to_cnt       <= '0;
            to_hit       <= 1'b0;
            sync1        <= 1'b0;
            meas_wave    <= 1'b0;
            cmd_ready    <= 1'b1;
            res_valid    <= 1'b0;
            res_value    <= '0;
            res_channel  <= '0;
            res_status   <= STATUS_OK;
            meas_nReset  <= 1'b0;
            meas_enable  <= 1'b0;
            meas_samples <= '0;
        end else begin
            sync1       <= wave_sel_c;
            meas_wave   <= sync1;
            meas_nReset <= 1'b1;
            to_hit      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        res_channel  <= cmd_channel;
                        meas_samples <= cmd_samples;
                        to_limit     <= cmd_timeout;
                        cmd_ready    <= 1'b0;
                        if (bad_cmd_c) begin
                            state      <= ST_REPORT;
                            res_valid  <= 1'b1;
                            res_status <= STATUS_BAD_CMD;
                            res_value  <= '0;
                        end else begin
                            state       <= ST_CLEAR;
                            meas_nReset <= 1'b0;
                        end
                    end
                end

                ST_CLEAR: begin
                    settle_cnt <= 1'b0;
                    if (cmd_abort) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        state <= ST_SETTLE;
                    end
                end

                // two enable-low cycles flush stale wave state out of the synchroniser
                ST_SETTLE: begin
                    if (cmd_abort) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                    end else if (settle_cnt) begin
                        state       <= ST_MEASURE;
                        meas_enable <= 1'b1;
                        to_cnt      <= '0;
                    end else begin
                        settle_cnt <= 1'b1;
                    end
                end

                // timeout match is registered, so it takes effect one cycle after counter==limit-1
                ST_MEASURE: begin
                    if (cmd_abort) begin
                        state       <= ST_IDLE;
                        cmd_ready   <= 1'b1;
                        meas_enable <= 1'b0;
                    end else if (meas_done) begin
                        state       <= ST_REPORT;
                        meas_enable <= 1'b0;
                        res_valid   <= 1'b1;
                        res_value   <= meas_value;
                        res_status  <= STATUS_OK;
                    end else if (to_hit) begin
                        state       <= ST_REPORT;
                        meas_enable <= 1'b0;
                        res_valid   <= 1'b1;
                        res_value   <= '0;
                        res_status  <= STATUS_TIMEOUT;
                    end else begin
                        if (to_cnt != '1)
                            to_cnt <= to_cnt + TO_WIDTH'(1);
                        to_hit <= (to_limit != '0) && (to_cnt == to_limit - TO_WIDTH'(1));
                    end
                end

                ST_REPORT: begin
                    if (res_ready) begin
                        state     <= ST_IDLE;
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    cmd_ready   <= 1'b1;
                    res_valid   <= 1'b0;
                    meas_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Randomised self-checking bench for freq_meas_sequencer with a transaction-level
// reference model predicting status, value and result latency per command.
module tb_freq_meas_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 8;
    localparam int unsigned CW = 8;
    localparam int unsigned TW = 24;

    logic          Clock;
    logic          nReset;
    logic [NC-1:0] in_waves;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_channel;
    logic [DW-1:0] cmd_samples;
    logic [TW-1:0] cmd_timeout;
    logic          cmd_abort;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_value;
    logic [CW-1:0] res_channel;
    logic [1:0]    res_status;
    logic          meas_nReset;
    logic          meas_enable;
    logic [DW-1:0] meas_samples;
    logic          meas_wave;
    logic          meas_done;
    logic [DW-1:0] meas_value;

    int checks = 0;
    int errors = 0;

    logic          osc = 1'b0;
    logic          osc_en = 1'b0;
    int            osc_ch = 0;
    logic [NC-1:0] wave_base = '0;

    int            obs_lat, obs_en_cyc, obs_idle_cyc, obs_nrst_low, obs_samp_bad;
    logic [DW-1:0] obs_val;
    logic [1:0]    obs_st;
    logic [CW-1:0] obs_ch;

    freq_meas_sequencer #(
        .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .CH_WIDTH(CW), .TO_WIDTH(TW)
    ) dut (
        .Clock(Clock), .nReset(nReset), .in_waves(in_waves),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_channel(cmd_channel),
        .cmd_samples(cmd_samples), .cmd_timeout(cmd_timeout), .cmd_abort(cmd_abort),
        .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value),
        .res_channel(res_channel), .res_status(res_status),
        .meas_nReset(meas_nReset), .meas_enable(meas_enable), .meas_samples(meas_samples),
        .meas_wave(meas_wave), .meas_done(meas_done), .meas_value(meas_value)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // 10-cycle square wave for the selected oscillating channel
    initial forever #50 osc = ~osc;

    always_comb begin
        in_waves = wave_base;
        if (osc_en && osc) in_waves[osc_ch] = 1'b1;
    end

    // Reference model: result fields and cycles from acceptance to res_valid
    function automatic void predict(input int ch, input int smp, input int to, input int done_at,
                                    input logic [DW-1:0] val, output logic [1:0] st,
                                    output logic [DW-1:0] v, output int lat);
        int last_ok;
        if (smp == 0 || ch >= int'(NC)) begin
            st = 2'b10; v = '0; lat = 1;
        end else begin
            last_ok = (to == 0) ? 32'h7fff_ffff : to + 1;
            if (done_at > 0 && done_at <= last_ok) begin
                st = 2'b00; v = val; lat = 4 + done_at;
            end else begin
                st = 2'b01; v = '0; lat = 5 + to;
            end
        end
    endfunction

    task automatic run_cmd(input int ch, input int smp, input int to, input int done_at,
                           input logic [DW-1:0] val, input int abort_at);
        int j;
        cmd_valid   = 1'b1;
        cmd_channel = CW'(ch);
        cmd_samples = DW'(smp);
        cmd_timeout = TW'(to);
        obs_lat = -1; obs_en_cyc = -1; obs_idle_cyc = -1; obs_nrst_low = 0; obs_samp_bad = 0;
        @(posedge Clock); #1;
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc < 600; cyc++) begin
            if (meas_nReset === 1'b0) obs_nrst_low++;
            if (meas_enable === 1'b1 && obs_en_cyc < 0) obs_en_cyc = cyc;
            if (meas_enable === 1'b1 && meas_samples !== DW'(smp)) obs_samp_bad++;
            if (res_valid === 1'b1) begin
                obs_lat = cyc; obs_val = res_value; obs_st = res_status; obs_ch = res_channel;
                break;
            end
            if (cmd_ready === 1'b1) begin
                obs_idle_cyc = cyc;
                break;
            end
            meas_value = DW'($urandom);
            if (obs_en_cyc > 0) begin
                j = cyc - obs_en_cyc + 1;
                if (done_at > 0 && j >= done_at) begin
                    meas_done  = 1'b1;
                    meas_value = val;
                end
                cmd_abort = (j == abort_at);
            end
            @(posedge Clock); #1;
        end
        meas_done = 1'b0;
        cmd_abort = 1'b0;
    endtask

    task automatic ack_result(input int hold, output int unstable, output logic rv_after,
                              output logic cr_after);
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge Clock); #1;
            if (res_valid !== 1'b1 || res_value !== obs_val || res_status !== obs_st ||
                res_channel !== obs_ch || meas_enable !== 1'b0) unstable++;
        end
        res_ready = 1'b1;
        @(posedge Clock); #1;
        res_ready = 1'b0;
        rv_after = res_valid;
        cr_after = cmd_ready;
    endtask

    task automatic test_reset();
        logic [DW+CW+7:0] got;
        nReset = 1'b0; cmd_valid = 1'b0; cmd_channel = '0; cmd_samples = '0; cmd_timeout = '0;
        cmd_abort = 1'b0; res_ready = 1'b0; meas_done = 1'b0; meas_value = '0;
        #12;
        got = {cmd_ready, res_valid, res_value, res_channel, res_status, meas_nReset,
               meas_enable, meas_wave};
        checks++;
        if (got !== {1'b1, 1'b0, DW'(0), CW'(0), 2'b00, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_outputs got %h exp cmd_ready only", got);
        end
        checks++;
        if (meas_samples !== '0) begin errors++; $display("FAIL reset_samples got %0d exp 0", meas_samples); end
        @(posedge Clock); #1;
        nReset = 1'b1;
        checks++;
        if (meas_nReset !== 1'b0) begin errors++; $display("FAIL reset_release_nrst got %b exp 0", meas_nReset); end
        @(posedge Clock); #1;
        checks++;
        if (meas_nReset !== 1'b1) begin errors++; $display("FAIL reset_first_clk_nrst got %b exp 1", meas_nReset); end
    endtask

    task automatic test_measure_ok();
        logic [DW-1:0] val, ev;
        logic [1:0] est;
        int elat, uns;
        logic rv, cr;
        val = DW'($urandom_range(25, 35));
        osc_ch = 3; osc_en = 1'b1;
        predict(3, 4, 0, 30, val, est, ev, elat);
        run_cmd(3, 4, 0, 30, val, 0);
        checks++; if (obs_en_cyc !== 4) begin errors++; $display("FAIL ok_enable_cycle got %0d exp 4", obs_en_cyc); end
        checks++; if (obs_nrst_low !== 1) begin errors++; $display("FAIL ok_nrst_pulse got %0d exp 1", obs_nrst_low); end
        checks++; if (obs_lat !== elat) begin errors++; $display("FAIL ok_latency got %0d exp %0d", obs_lat, elat); end
        checks++; if (obs_st !== est || obs_val !== ev || obs_ch !== CW'(3)) begin
            errors++; $display("FAIL ok_result got st %0d val %0d ch %0d exp st %0d val %0d ch 3", obs_st, obs_val, obs_ch, est, ev);
        end
        checks++; if (obs_samp_bad !== 0) begin errors++; $display("FAIL ok_meas_samples got %0d bad cycles exp 0", obs_samp_bad); end
        ack_result(5, uns, rv, cr);
        checks++; if (uns !== 0) begin errors++; $display("FAIL ok_hold got %0d unstable exp 0", uns); end
        checks++; if (rv !== 1'b0 || cr !== 1'b1) begin errors++; $display("FAIL ok_handshake got rv %b cr %b exp 0 1", rv, cr); end
        osc_en = 1'b0;
    endtask

    task automatic test_wave_path();
        wave_base = '0;
        repeat (3) @(posedge Clock);
        #1;
        checks++; if (meas_wave !== 1'b0) begin errors++; $display("FAIL wave_idle got %b exp 0", meas_wave); end
        wave_base = 8'h08;
        @(posedge Clock); #1;
        checks++; if (meas_wave !== 1'b0) begin errors++; $display("FAIL wave_sync_1st got %b exp 0", meas_wave); end
        @(posedge Clock); #1;
        checks++; if (meas_wave !== 1'b1) begin errors++; $display("FAIL wave_sync_2nd got %b exp 1", meas_wave); end
        wave_base = 8'hF7;
        repeat (2) @(posedge Clock);
        #1;
        checks++; if (meas_wave !== 1'b0) begin errors++; $display("FAIL wave_other_channels got %b exp 0", meas_wave); end
        wave_base = '0;
    endtask

    task automatic test_timeout();
        int uns;
        logic rv, cr;
        run_cmd(1, 5, 100, 0, '0, 0);
        checks++; if (obs_lat - obs_en_cyc !== 101) begin
            errors++; $display("FAIL timeout_latency got %0d exp 101", obs_lat - obs_en_cyc);
        end
        checks++; if (obs_st !== 2'b01 || obs_val !== '0 || obs_ch !== CW'(1)) begin
            errors++; $display("FAIL timeout_result got st %0d val %0d ch %0d exp 1 0 1", obs_st, obs_val, obs_ch);
        end
        ack_result(1, uns, rv, cr);
        checks++; if (uns !== 0 || rv !== 1'b0 || cr !== 1'b1) begin
            errors++; $display("FAIL timeout_handshake got uns %0d rv %b cr %b exp 0 0 1", uns, rv, cr);
        end
    endtask

    task automatic test_bad_cmd();
        int chs[3] = '{9, 2, 255};
        int sms[3] = '{5, 0, 7};
        int uns;
        logic rv, cr;
        for (int k = 0; k < 3; k++) begin
            run_cmd(chs[k], sms[k], 50, 3, 16'h1234, 0);
            checks++; if (obs_lat !== 1 || obs_st !== 2'b10 || obs_val !== '0 || obs_ch !== CW'(chs[k])) begin
                errors++; $display("FAIL bad_cmd_%0d got lat %0d st %0d val %0d ch %0d exp 1 2 0 %0d", k, obs_lat, obs_st, obs_val, obs_ch, chs[k]);
            end
            checks++; if (obs_nrst_low !== 0 || obs_en_cyc !== -1) begin
                errors++; $display("FAIL bad_cmd_unit_%0d got nrst_low %0d en %0d exp 0 -1", k, obs_nrst_low, obs_en_cyc);
            end
            ack_result(k, uns, rv, cr);
            checks++; if (uns !== 0 || rv !== 1'b0 || cr !== 1'b1) begin
                errors++; $display("FAIL bad_cmd_hs_%0d got uns %0d rv %b cr %b exp 0 0 1", k, uns, rv, cr);
            end
        end
    endtask

    task automatic test_abort();
        int rv_seen = 0;
        int uns;
        logic rv, cr;
        run_cmd(5, 3, 0, 0, '0, 2);
        checks++; if (obs_idle_cyc !== 6 || obs_lat !== -1) begin
            errors++; $display("FAIL abort_return got idle %0d lat %0d exp 6 -1", obs_idle_cyc, obs_lat);
        end
        checks++; if (meas_enable !== 1'b0) begin errors++; $display("FAIL abort_enable got %b exp 0", meas_enable); end
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock); #1;
            if (res_valid !== 1'b0) rv_seen++;
        end
        checks++; if (rv_seen !== 0) begin errors++; $display("FAIL abort_no_result got %0d exp 0", rv_seen); end
        run_cmd(2, 6, 0, 12, 16'h0abc, 0);
        checks++; if (obs_lat !== 16 || obs_st !== 2'b00 || obs_val !== 16'h0abc) begin
            errors++; $display("FAIL abort_followup got lat %0d st %0d val %0d exp 16 0 2748", obs_lat, obs_st, obs_val);
        end
        ack_result(0, uns, rv, cr);
    endtask

    task automatic test_done_timeout_tie();
        int to, elat, uns;
        int offs[3] = '{0, 1, 2};
        logic [DW-1:0] val, ev;
        logic [1:0] est;
        logic rv, cr;
        to = $urandom_range(3, 40);
        for (int k = 0; k < 3; k++) begin
            val = DW'($urandom_range(1, 65535));
            predict(6, 9, to, to + offs[k], val, est, ev, elat);
            run_cmd(6, 9, to, to + offs[k], val, 0);
            checks++; if (obs_lat !== elat || obs_st !== est || obs_val !== ev) begin
                errors++; $display("FAIL tie_%0d got lat %0d st %0d val %0d exp %0d %0d %0d", k, obs_lat, obs_st, obs_val, elat, est, ev);
            end
            ack_result(1, uns, rv, cr);
        end
    endtask

    task automatic test_random();
        int ch, smp, to, done_at, elat, uns;
        logic [DW-1:0] val, ev;
        logic [1:0] est;
        logic rv, cr;
        for (int k = 0; k < 15; k++) begin
            ch      = $urandom_range(0, 10);
            smp     = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 65535);
            to      = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
            done_at = $urandom_range(1, 70);
            val     = DW'($urandom);
            predict(ch, smp, to, done_at, val, est, ev, elat);
            run_cmd(ch, smp, to, done_at, val, 0);
            checks++; if (obs_lat !== elat || obs_st !== est || obs_val !== ev || obs_ch !== CW'(ch)) begin
                errors++; $display("FAIL random_%0d got lat %0d st %0d val %0d ch %0d exp %0d %0d %0d %0d",
                                   k, obs_lat, obs_st, obs_val, obs_ch, elat, est, ev, ch);
            end
            ack_result($urandom_range(0, 3), uns, rv, cr);
            checks++; if (uns !== 0 || rv !== 1'b0 || cr !== 1'b1) begin
                errors++; $display("FAIL random_hs_%0d got uns %0d rv %b cr %b exp 0 0 1", k, uns, rv, cr);
            end
        end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        cmd_valid = 1'b1; cmd_channel = CW'(4); cmd_samples = DW'(8); cmd_timeout = '0;
        @(posedge Clock); #1;
        cmd_valid = 1'b0;
        while (meas_enable !== 1'b1 && waited < 20) begin
            @(posedge Clock); #1;
            waited++;
        end
        checks++; if (meas_enable !== 1'b1) begin errors++; $display("FAIL midrst_reach_measure got %b exp 1", meas_enable); end
        repeat (3) @(posedge Clock);
        #1;
        nReset = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_value !== '0 || res_channel !== '0 ||
            res_status !== 2'b00 || meas_nReset !== 1'b0 || meas_enable !== 1'b0 ||
            meas_samples !== '0 || meas_wave !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got rdy %b rv %b ch %0d nrst %b en %b smp %0d exp 1 0 0 0 0 0",
                               cmd_ready, res_valid, res_channel, meas_nReset, meas_enable, meas_samples);
        end
        @(posedge Clock); #1;
        nReset = 1'b1;
        checks++; if (meas_nReset !== 1'b0) begin errors++; $display("FAIL midrst_release got %b exp 0", meas_nReset); end
        @(posedge Clock); #1;
        checks++; if (meas_nReset !== 1'b1 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_after_clk got nrst %b rdy %b rv %b exp 1 1 0", meas_nReset, cmd_ready, res_valid);
        end
    endtask

    initial begin
        test_reset();
        test_measure_ok();
        test_wave_path();
        test_timeout();
        test_bad_cmd();
        test_abort();
        test_done_timeout_tie();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_meas_sequencer.md
# freq_meas_sequencer

Command-driven controller that sequences a single frequency-measurement datapath across several DUT output pins. It accepts a measurement command (channel, sample count, timeout), selects and synchronises the chosen input wave, and clears and enables the measurement unit. It then waits for the unit's done flag or a timeout, and returns the count with a status code over a valid/ready result port. It sits between the host command interface and the measurement unit.

## Interface
- DATA_WIDTH, 16: width of sample count and measured value (matches measurement unit)
- NUM_CHANNELS, 8: number of selectable input waves (2..256)
- CH_WIDTH, 8: width of channel index
- TO_WIDTH, 24: width of timeout count

- Clock  in  1  system clock
- nReset  in  1  asynchronous active-low reset
- in_waves  in  NUM_CHANNELS  asynchronous DUT outputs
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_channel  in  CH_WIDTH  channel index
- cmd_samples  in  DATA_WIDTH  rising edges to measure over
- cmd_timeout  in  TO_WIDTH  max MEASURE cycles; 0 = no timeout
- cmd_abort  in  1  abandon current measurement
- res_valid  out  1  result present
- res_ready  in  1  result consumed
- res_value  out  DATA_WIDTH  measured count
- res_channel  out  CH_WIDTH  channel of this result
- res_status  out  2  00 OK, 01 TIMEOUT, 10 BAD_CMD
- meas_nReset  out  1  registered reset to measurement unit
- meas_enable  out  1  enable to measurement unit
- meas_samples  out  DATA_WIDTH  latched cmd_samples
- meas_wave  out  1  selected, synchronised wave
- meas_done  in  1  done flag from measurement unit (sticky until its reset)
- meas_value  in  DATA_WIDTH  count from measurement unit

## Operation
- FSM states: IDLE, CLEAR, SETTLE, MEASURE, REPORT.
- **IDLE**
  - cmd_ready=1, meas_enable=0.
  - On cmd_valid&cmd_ready: latch channel, samples and timeout.
  - If cmd_samples==0 or cmd_channel>=NUM_CHANNELS: go to REPORT with status BAD_CMD and res_value=0.
  - Otherwise go to CLEAR.
- **CLEAR** (1 cycle): meas_nReset=0.
- **SETTLE** (2 cycles, counted): meas_nReset=1, meas_enable=0. This flushes the synchroniser.
- **MEASURE**
  - meas_enable=1; timeout counter starts at 0 and increments each cycle.
  - meas_done=1: capture meas_value, status OK, go to REPORT.
  - Otherwise, cmd_timeout!=0 and counter==cmd_timeout-1: status TIMEOUT, res_value=0, go to REPORT.
  - Done and timeout in the same cycle: done wins.
- **REPORT**
  - res_valid=1; res_value, res_channel and res_status are held stable and meas_enable=0.
  - On res_ready: go to IDLE.
- **Abort**
  - cmd_abort in CLEAR, SETTLE or MEASURE returns to IDLE next cycle with no result, and meas_enable drops.
  - cmd_abort is ignored in IDLE and REPORT.
- **Wave path**
  - Mux in_waves[latched channel], then a 2-flop synchroniser; meas_wave is the second flop.
  - The mux index changes only on command acceptance.
- **meas_nReset** is a dedicated flop, so it is glitch-free.
- **Timeout counter** saturates at all-ones and never wraps.
- **Reset values:** state IDLE, cmd_ready=1, res_valid=0, res_value=0, res_channel=0, res_status=00, meas_nReset=0, meas_enable=0, meas_samples=0, meas_wave=0, sync flops 0, timeout counter 0.
  - meas_nReset goes to 1 on the first clock after reset release.
- **Reset mid-operation:** all state is cleared immediately; any pending result is lost.

## Timing
- Command accepted at edge E0.
- Cycle after E0: state CLEAR, meas_nReset=0, cmd_ready=0.
- Next two cycles: SETTLE.
- Fourth cycle after E0: meas_enable=1.
- meas_done sampled high at edge Ed: res_valid=1 in the cycle after Ed.
- Timeout T: res_valid is asserted exactly T+1 cycles after MEASURE entry.
- BAD_CMD: res_valid=1 in the cycle after acceptance.
- Result handshake completes on an edge with res_valid&res_ready.
  - cmd_ready=1 the following cycle.
  - No back-to-back command and result in the same cycle.
- res_valid never deasserts without res_ready (or reset).

## Test plan
- Channel 3, samples=4, timeout=0, in_waves[3] period 10 cycles, other channels static -> res_status=00, res_channel=3, res_value equals the measurement unit's count (≈30 for 3 periods), res_valid held until res_ready.
- Channel 1, samples=5, timeout=100, in_waves[1] constant 0 -> res_valid exactly 101 cycles after meas_enable rises, status 01, value 0.
- Channel 9 with NUM_CHANNELS=8 (or samples=0) -> status 10, value 0, res_valid one cycle after acceptance, meas_nReset never pulses.
- Command accepted, cmd_abort asserted on the second MEASURE cycle -> IDLE next cycle, meas_enable=0, no res_valid; a new command then completes normally.
- meas_done asserted on the same cycle the timeout fires -> status 00 with captured meas_value.
- nReset asserted during MEASURE and released -> all outputs at reset values, meas_nReset=0 then 1 after the first clock, cmd_ready=1.
